// File: rtl/spare_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spare_mon_pkg
// Purpose  : Shared types and parameter limits for the spare-cell tie-low
//            monitor: scan FSM state type, legal parameter ranges and a
//            helper that sizes the scan index.
// Revision : 1.0 - initial release
// ============================================================================
package spare_mon_pkg;

    // Scan controller states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Legal parameter ranges
    localparam int unsigned C_NUM_CELLS_MIN = 1;
    localparam int unsigned C_NUM_CELLS_MAX = 32;
    localparam int unsigned C_DEBOUNCE_MIN  = 1;
    localparam int unsigned C_DEBOUNCE_MAX  = 15;
    localparam int unsigned C_SCAN_DIV_MIN  = 2;
    localparam int unsigned C_SCAN_DIV_MAX  = 256;

    // Index width for a given line count; a single line still gets one bit
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : spare_mon_pkg
`default_nettype wire

// File: rtl/spare_mon_sync2.sv
`default_nettype none
// ============================================================================
// Module   : spare_mon_sync2
// Purpose  : Two-flop synchronizer bringing asynchronous tie-low lines into
//            the monitor clock domain. Both stages clear on reset.
// Revision : 1.0 - initial release
// ============================================================================
module spare_mon_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Metastability stage followed by the stable output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : spare_mon_sync2
`default_nettype wire

// File: rtl/spare_tie_monitor.sv
`default_nettype none
// ============================================================================
// Module   : spare_tie_monitor
// Purpose  : Round-robin monitor for spare-cell tie-low outputs. Each line is
//            sampled once per scan step; a line seen high DEBOUNCE times in a
//            row latches a sticky fault bit.
// Options  : SPARE_MON_IRQ_EN - when defined, builds a one-cycle new-fault
//            interrupt on irq_o; otherwise irq_o is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module spare_tie_monitor
    import spare_mon_pkg::*;
#(
    parameter  int NUM_CELLS = 4,
    parameter  int DEBOUNCE  = 3,
    parameter  int SCAN_DIV  = 16,
    localparam int IDX_W     = idx_width(NUM_CELLS)
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 en_i,
    input  logic [NUM_CELLS-1:0] lo_i,
    input  logic                 clr_i,
    output logic [NUM_CELLS-1:0] fault_o,
    output logic                 fault_any_o,
    output logic [IDX_W-1:0]     scan_idx_o,
    output logic                 sweep_done_o,
    output logic                 irq_o
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NUM_CELLS - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(DEBOUNCE);

    // Reject out-of-range configurations at elaboration
    if (NUM_CELLS < C_NUM_CELLS_MIN || NUM_CELLS > C_NUM_CELLS_MAX) begin : g_bad_num_cells
        $error("spare_tie_monitor: NUM_CELLS out of range");
    end
    if (DEBOUNCE < C_DEBOUNCE_MIN || DEBOUNCE > C_DEBOUNCE_MAX) begin : g_bad_debounce
        $error("spare_tie_monitor: DEBOUNCE out of range");
    end
    if (SCAN_DIV < C_SCAN_DIV_MIN || SCAN_DIV > C_SCAN_DIV_MAX) begin : g_bad_scan_div
        $error("spare_tie_monitor: SCAN_DIV out of range");
    end

    state_t               r_state;
    state_t               w_state_next;
    logic [PRE_W-1:0]     r_presc;
    logic [IDX_W-1:0]     r_idx;
    logic [NUM_CELLS-1:0] r_fault;
    logic [NUM_CELLS-1:0] w_lo_sync;
    logic [NUM_CELLS-1:0] w_set;
    logic                 w_strobe;

    spare_mon_sync2 #(
        .WIDTH (NUM_CELLS)
    ) u_sync (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .i_d (lo_i),
        .o_q (w_lo_sync)
    );

    // Scan controller state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and strobe decode; strobes only while scanning and enabled
    always_comb begin
        w_state_next = r_state;
        w_strobe     = 1'b0;
        case (r_state)
            IDLE: begin
                if (en_i) begin
                    w_state_next = SCAN;
                end
            end
            SCAN: begin
                if (!en_i) begin
                    w_state_next = IDLE;
                end else begin
                    w_strobe = (r_presc == C_PRE_LAST);
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Prescaler: starts counting in the cycle en_i rises so the first strobe
    // lands SCAN_DIV-1 cycles after enable; held at 0 whenever disabled
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !en_i) begin
            r_presc <= '0;
        end else if (r_presc == C_PRE_LAST) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRE_W'(1);
        end
    end

    // Scan index advances on each strobe and wraps after the last line
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !en_i) begin
            r_idx <= '0;
        end else if (w_strobe) begin
            if (r_idx == C_IDX_LAST) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    // One saturating debounce counter per line
    for (genvar i = 0; i < NUM_CELLS; i++) begin : g_line
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_inc;
        logic             w_sel;

        assign w_sel     = w_strobe && (r_idx == IDX_W'(i));
        assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? C_CNT_MAX : (r_cnt + CNT_W'(1));
        assign w_set[i]  = w_sel && w_lo_sync[i] && (w_cnt_inc == C_CNT_MAX);

        // Count consecutive high samples; a low sample restarts the run
        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i || !en_i || clr_i) begin
                r_cnt <= '0;
            end else if (w_sel) begin
                r_cnt <= w_lo_sync[i] ? w_cnt_inc : '0;
            end
        end
    end

    // Sticky fault bits; a same-cycle set overrides a clear request
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_fault <= '0;
        end else begin
            r_fault <= (clr_i ? '0 : r_fault) | w_set;
        end
    end

`ifdef SPARE_MON_IRQ_EN
    logic [NUM_CELLS-1:0] r_fault_d;
    logic                 r_irq;

    // Edge-detect any newly set fault bit into a single-cycle pulse
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_fault_d <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_fault_d <= r_fault;
            r_irq     <= |(r_fault & ~r_fault_d);
        end
    end

    assign irq_o = r_irq;
`else
    assign irq_o = 1'b0;
`endif

    assign fault_o      = r_fault;
    assign fault_any_o  = |r_fault;
    assign scan_idx_o   = r_idx;
    assign sweep_done_o = w_strobe && (r_idx == C_IDX_LAST);

endmodule : spare_tie_monitor
`default_nettype wire

// File: tb/tb_spare_tie_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_spare_tie_monitor
// Purpose  : Self-checking bench for spare_tie_monitor (NUM_CELLS=4,
//            DEBOUNCE=3, SCAN_DIV=4). Stimulus queues expected snapshots,
//            sweep pulses and irq pulses; a negedge monitor checks them.
// Options  : SPARE_MON_IRQ_EN - expected irq pulses follow the DUT build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spare_tie_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] lo  = 4'b0000;
    logic [3:0] fault_o;
    logic       fault_any_o;
    logic [1:0] scan_idx_o;
    logic       sweep_done_o;
    logic       irq_o;

    always #5 clk = ~clk;

    spare_tie_monitor #(
        .NUM_CELLS (4),
        .DEBOUNCE  (3),
        .SCAN_DIV  (4)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .en_i         (en),
        .lo_i         (lo),
        .clr_i        (clr),
        .fault_o      (fault_o),
        .fault_any_o  (fault_any_o),
        .scan_idx_o   (scan_idx_o),
        .sweep_done_o (sweep_done_o),
        .irq_o        (irq_o)
    );

    typedef struct {
        int         cyc;
        logic [3:0] fault;
        int         idx;    // -1: index not checked
        bit         zp;     // also require sweep_done_o and irq_o low
    } snap_t;

    snap_t snap_q[$];
    int    sweep_q[$];
    int    irq_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int base     = 0;

    snap_t      m_snap;
    int         m_exp;
    logic [1:0] m_idx;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (sweep_done_o) begin
            checks++;
            if (sweep_q.size() == 0) begin
                failures++;
                $display("FAIL sweep_done: pulse at cycle %0d (rel %0d), required no pulse", cyc, cyc - base);
            end else begin
                m_exp = sweep_q.pop_front();
                if (m_exp != cyc) begin
                    failures++;
                    $display("FAIL sweep_done: pulse at cycle %0d, required cycle %0d", cyc, m_exp);
                end
            end
        end
        if (irq_o) begin
            checks++;
            if (irq_q.size() == 0) begin
                failures++;
                $display("FAIL irq: pulse at cycle %0d (rel %0d), required no pulse", cyc, cyc - base);
            end else begin
                m_exp = irq_q.pop_front();
                if (m_exp != cyc) begin
                    failures++;
                    $display("FAIL irq: pulse at cycle %0d, required cycle %0d", cyc, m_exp);
                end
            end
        end
        while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
            m_snap = snap_q.pop_front();
            checks++;
            if (m_snap.cyc != cyc) begin
                failures++;
                $display("FAIL snapshot: sampled at cycle %0d, required cycle %0d", cyc, m_snap.cyc);
            end else begin
                if (fault_o !== m_snap.fault) begin
                    failures++;
                    $display("FAIL fault_o at rel %0d: got %b, required %b", cyc - base, fault_o, m_snap.fault);
                end
                checks++;
                if (fault_any_o !== (|m_snap.fault)) begin
                    failures++;
                    $display("FAIL fault_any_o at rel %0d: got %b, required %b", cyc - base, fault_any_o, |m_snap.fault);
                end
                if (m_snap.idx >= 0) begin
                    m_idx = m_snap.idx[1:0];
                    checks++;
                    if (scan_idx_o !== m_idx) begin
                        failures++;
                        $display("FAIL scan_idx_o at rel %0d: got %0d, required %0d", cyc - base, scan_idx_o, m_idx);
                    end
                end
                if (m_snap.zp) begin
                    checks++;
                    if (sweep_done_o !== 1'b0 || irq_o !== 1'b0) begin
                        failures++;
                        $display("FAIL pulses_low at rel %0d: sweep_done=%b irq=%b, required 0 0", cyc - base, sweep_done_o, irq_o);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go_to(input int rel);
        if (rel > cyc - base) tick(rel - (cyc - base));
    endtask

    task automatic exp_snap(input int rel, input logic [3:0] f, input int idx, input bit zp);
        snap_q.push_back('{cyc: base + rel, fault: f, idx: idx, zp: zp});
    endtask

    task automatic exp_sweeps(input int count);
        for (int k = 0; k < count; k++) sweep_q.push_back(base + 15 + 16 * k);
    endtask

    task automatic exp_irq(input int rel);
`ifdef SPARE_MON_IRQ_EN
        irq_q.push_back(base + rel);
`else
        if (rel < 0) irq_q.push_back(base + rel);
`endif
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic start_scan();
        en   = 1'b1;
        base = cyc;
    endtask

    task automatic drain(input string name);
        tick(4);
        checks++;
        if (snap_q.size() != 0 || sweep_q.size() != 0 || irq_q.size() != 0) begin
            failures++;
            $display("FAIL %s leftover: snaps=%0d sweeps=%0d irqs=%0d, required 0 0 0",
                     name, snap_q.size(), sweep_q.size(), irq_q.size());
            snap_q.delete();
            sweep_q.delete();
            irq_q.delete();
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        tick(2);

        // Reset state
        pulse_reset();
        base = cyc;
        exp_snap(0, 4'b0000, 0, 1'b1);
        tick(2);

        // All lines clean: no faults, sweeps every 16 cycles
        lo = 4'b0000;
        start_scan();
        exp_snap(0,  4'b0000, 0, 1'b0);
        exp_snap(20, 4'b0000, 1, 1'b0);
        exp_snap(63, 4'b0000, 3, 1'b0);
        exp_sweeps(4);
        go_to(64);
        en = 1'b0;
        drain("clean");

        // Line 2 stuck high; clear at 100, clear colliding with a set at 139
        lo = 4'b0100;
        pulse_reset();
        tick(3);
        start_scan();
        exp_snap(43,  4'b0000, -1, 1'b0);
        exp_snap(44,  4'b0100,  3, 1'b0);
        exp_irq(45);
        exp_snap(100, 4'b0100,  1, 1'b0);
        exp_snap(101, 4'b0000, -1, 1'b0);
        exp_snap(106, 4'b0000, -1, 1'b0);
        exp_snap(139, 4'b0000, -1, 1'b0);
        exp_snap(140, 4'b0100, -1, 1'b0);
        exp_irq(141);
        exp_snap(149, 4'b0100, -1, 1'b0);
        exp_sweeps(9);
        go_to(100);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        go_to(139);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        go_to(150);
        en = 1'b0;
        drain("line2");

        // Line 1 high for two samples only, then a fresh run of three
        lo = 4'b0000;
        pulse_reset();
        tick(3);
        start_scan();
        lo = 4'b0010;
        exp_snap(40, 4'b0000, -1, 1'b0);
        exp_snap(56, 4'b0000, -1, 1'b0);
        exp_snap(87, 4'b0000, -1, 1'b0);
        exp_snap(88, 4'b0010, -1, 1'b0);
        exp_irq(89);
        exp_sweeps(6);
        go_to(31);
        lo = 4'b0000;
        go_to(40);
        lo = 4'b0010;
        go_to(96);
        en = 1'b0;
        drain("line1");

        // Fault on line 0, then enable drop mid-sweep, then reset override
        lo = 4'b0001;
        pulse_reset();
        tick(3);
        start_scan();
        exp_snap(35, 4'b0000, -1, 1'b0);
        exp_snap(36, 4'b0001, -1, 1'b0);
        exp_irq(37);
        exp_snap(41, 4'b0001, 0, 1'b1);
        exp_snap(45, 4'b0001, 0, 1'b0);
        exp_sweeps(2);
        go_to(36);
        lo = 4'b0000;
        go_to(40);
        en = 1'b0;
        go_to(50);
        start_scan();
        exp_snap(19, 4'b0001, 0, 1'b0);
        exp_snap(20, 4'b0001, 1, 1'b0);
        exp_snap(21, 4'b0001, 0, 1'b1);
        exp_snap(26, 4'b0000, 0, 1'b1);
        exp_snap(27, 4'b0000, 0, 1'b1);
        exp_sweeps(1);
        go_to(20);
        en = 1'b0;
        go_to(25);
        en  = 1'b1;
        clr = 1'b1;
        lo  = 4'b1111;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        clr = 1'b0;
        en  = 1'b0;
        drain("endrop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_spare_tie_monitor
`default_nettype wire

// File: doc/spare_tie_monitor.md
SPARE_TIE_MONITOR -- requirements
Module: spare_tie_monitor

Interface
REQ-001 Parameter NUM_CELLS, default 4, SHALL set the number of monitored spare-cell tie-low lines (range 1..32).
REQ-002 Parameter DEBOUNCE, default 3, SHALL set the consecutive high samples of one line needed to declare a fault (range 1..15).
REQ-003 Parameter SCAN_DIV, default 16, SHALL set the clock cycles per scan step (range 2..256).
REQ-004 wb_clk_i  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-005 wb_rst_i  input  1  SHALL be the synchronous, active-high reset.
REQ-006 en_i  input  1  SHALL enable scanning when high.
REQ-007 lo_i  input  NUM_CELLS  SHALL carry the LO outputs of the spare-cell macros (expected constant 0).
REQ-008 clr_i  input  1  SHALL be a single-cycle request to clear all sticky faults and debounce counters.
REQ-009 fault_o  output  NUM_CELLS  SHALL hold one sticky fault bit per line.
REQ-010 fault_any_o  output  1  SHALL be the OR of fault_o.
REQ-011 scan_idx_o  output  clog2(NUM_CELLS), min 1  SHALL show the index sampled at the next strobe.
REQ-012 sweep_done_o  output  1  SHALL pulse for one cycle when the last index is sampled.
REQ-013 irq_o  output  1  SHALL be the new-fault interrupt pulse (see Configuration).

Function
REQ-014 lo_i SHALL pass through a 2-flop synchronizer before use; sampling uses the synchronized value.
REQ-015 FSM states SHALL be IDLE and SCAN; IDLE->SCAN when en_i=1, SCAN->IDLE when en_i=0.
REQ-016 In SCAN the prescaler SHALL count 0..SCAN_DIV-1 and wrap, generating a strobe in the cycle it equals SCAN_DIV-1.
REQ-017 In the strobe cycle, line idx SHALL be sampled and idx SHALL advance, wrapping from NUM_CELLS-1 to 0.
REQ-018 If the sample is 1, that line's counter SHALL increment, saturating at DEBOUNCE. If the sample is 0, the counter SHALL clear to 0.
REQ-019 When a counter reaches DEBOUNCE, the matching fault_o bit SHALL set one cycle after the strobe and stay set until clr_i or reset.
REQ-020 clr_i SHALL clear all fault_o bits and counters on the next edge. If a set for the same line falls in the same cycle, the set SHALL win.
REQ-021 Dropping en_i mid-sweep SHALL return the FSM to IDLE next cycle, with prescaler=0, idx=0 and counters cleared. fault_o SHALL be held.
REQ-022 sweep_done_o SHALL be asserted in the strobe cycle where idx=NUM_CELLS-1.
REQ-023 With NUM_CELLS=1, idx SHALL stay 0 and sweep_done_o SHALL pulse on every strobe.

Reset
REQ-024 On wb_rst_i the following SHALL be driven the next cycle, with reset overriding en_i and clr_i:
- FSM=IDLE
- prescaler=0, idx=0
- counters=0, synchronizer flops=0
- fault_o=0, sweep_done_o=0, irq_o=0

Configuration
REQ-025 With macro SPARE_MON_IRQ_EN defined, irq_o SHALL pulse for one cycle, one cycle after any fault_o bit goes 0->1. Multiple bits setting together SHALL give one pulse.
REQ-026 Without SPARE_MON_IRQ_EN, irq_o SHALL be tied 0 and no interrupt logic SHALL be built; all other behaviour is identical.

Structure
REQ-027 Package spare_mon_pkg SHALL hold the FSM state typedef (IDLE, SCAN) and the parameter range-limit constants.
REQ-028 The 2-flop synchronizer SHALL be sub-module spare_mon_sync2, parameterised by width.
REQ-029 Total RTL SHALL be 120-400 lines.

Verification (NUM_CELLS=4, DEBOUNCE=3, SCAN_DIV=4; cycle 0 = first cycle with en_i=1)
REQ-030 lo_i=4'b0000, en_i=1 for 64 cycles: fault_o stays 0, irq_o stays 0, and sweep_done_o pulses at cycles 15, 31, 47 and 63.
REQ-031 lo_i=4'b0100 from before reset release: line 2 is sampled at cycles 11, 27 and 43. fault_o=4'b0100 from cycle 44, and irq_o pulses at cycle 45 (macro on) or stays 0 (macro off).
REQ-032 lo_i[1]=1 for cycles 0..30, then 0: no fault results, and line 1's counter is 0 after the cycle-39 sample.
REQ-033 With fault_o=4'b0100 and lo_i[2] still 1, clr_i at cycle 100: fault_o=0 from cycle 101 and re-sets after three more line-2 samples.
REQ-034 Edge cases:
- clr_i coincides with a line-2 set: fault_o[2] remains 1.
- en_i dropped at cycle 20 with fault_o=4'b0001: FSM goes to IDLE, scan_idx_o=0, fault_o stays 4'b0001.
- wb_rst_i: all outputs read 0 the next cycle.
